// File: rtl/buf_rx_fifo.sv
// Four-phase REQ/ACK receiver that queues each word in a small FIFO with a valid/ready output.
// Optional sequence checker enabled by defining BUF_RX_SEQ_CHECK_EN.
module buf_rx_fifo #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AW          = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             BtoR_REQ,
    input  logic [WIDTH-1:0] DO,
    output logic             RtoB_ACK,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW:0]      count,
    output logic             seq_err
);

    localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StCapture, StAck, StRelease} state_e;

    state_e                 state_q;
    logic                   ack_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   req_all;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW:0]            count_q;
    logic                   push;
    logic                   pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], BtoR_REQ};
        end
    end

    assign req_s   = sync_q[SYNC_STAGES-1];
    // Requiring every stage high rejects REQ pulses shorter than the synchronizer depth.
    assign req_all = &sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ack_q <= 1'b0;
                    if (req_all && (count_q != Full)) state_q <= StCapture;
                end
                StCapture: begin
                    state_q <= StAck;
                    ack_q   <= 1'b1;
                end
                StAck: begin
                    if (!req_s) begin
                        state_q <= StRelease;
                        ack_q   <= 1'b0;
                    end
                end
                StRelease: begin
                    state_q <= StIdle;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign push = (state_q == StCapture);
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= DO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef BUF_RX_SEQ_CHECK_EN
    logic [WIDTH-1:0] expect_q;
    logic             seq_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expect_q  <= '0;
            seq_err_q <= 1'b0;
        end else if (push) begin
            // Resync to the received value so one gap flags once, not on every later word.
            expect_q <= DO + 1'b1;
            if (DO != expect_q) seq_err_q <= 1'b1;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

    assign RtoB_ACK  = ack_q;
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: tb/tb_buf_rx_fifo.sv
// Directed bench for buf_rx_fifo: latency, ordering, backpressure, sequence check, reset, glitch.
module tb_buf_rx_fifo;

    localparam int unsigned WIDTH = 32;

`ifdef BUF_RX_SEQ_CHECK_EN
    localparam logic SeqOn = 1'b1;
`else
    localparam logic SeqOn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             BtoR_REQ = 1'b0;
    logic [WIDTH-1:0] DO = '0;
    logic             RtoB_ACK;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       count;
    logic             seq_err;

    int checks = 0;
    int failures = 0;
    int max_count = 0;

    buf_rx_fifo #(
        .WIDTH(WIDTH), .DEPTH(4), .AW(2), .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .BtoR_REQ  (BtoR_REQ),
        .DO        (DO),
        .RtoB_ACK  (RtoB_ACK),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (int'(count) > max_count) max_count = int'(count);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input logic v, input string tag);
        int n = 0;
        while (RtoB_ACK !== v && n < 40) begin
            step(1);
            n++;
        end
        chk(tag, {31'd0, RtoB_ACK}, {31'd0, v});
    endtask

    task automatic hs(input logic [WIDTH-1:0] w);
        DO = w;
        BtoR_REQ = 1'b1;
        wait_ack(1'b1, "hs_ack_rise");
        BtoR_REQ = 1'b0;
        wait_ack(1'b0, "hs_ack_fall");
        step(1);
    endtask

    task automatic do_reset();
        BtoR_REQ = 1'b0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_ack", {31'd0, RtoB_ACK}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_seq_err", {31'd0, seq_err}, 32'd0);

        // Single transfer latency
        DO = 32'h5;
        BtoR_REQ = 1'b1;
        step(3);
        chk("single_ack_c3", {31'd0, RtoB_ACK}, 32'd0);
        step(1);
        chk("single_ack_c4", {31'd0, RtoB_ACK}, 32'd1);
        chk("single_valid_c4", {31'd0, out_valid}, 32'd1);
        chk("single_data_c4", out_data, 32'h5);
        step(6);
        BtoR_REQ = 1'b0;
        step(2);
        chk("single_ack_c12", {31'd0, RtoB_ACK}, 32'd1);
        step(1);
        chk("single_ack_c13", {31'd0, RtoB_ACK}, 32'd0);
        out_ready = 1'b1;
        step(1);
        chk("single_popped", {29'd0, count}, 32'd0);

        // Streaming sequence 0..99
        do_reset();
        out_ready = 1'b1;
        max_count = 0;
        for (int i = 0; i < 100; i++) begin
            DO = i;
            BtoR_REQ = 1'b1;
            wait_ack(1'b1, "seq_ack_rise");
            chk("seq_valid", {31'd0, out_valid}, 32'd1);
            chk("seq_data", out_data, i);
            BtoR_REQ = 1'b0;
            wait_ack(1'b0, "seq_ack_fall");
            step(1);
        end
        chk("seq_max_count", max_count, 32'd1);
        chk("seq_err_clean", {31'd0, seq_err}, 32'd0);
        chk("seq_drained", {29'd0, count}, 32'd0);

        // Backpressure at full
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) hs(i);
        chk("bp_full", {29'd0, count}, 32'd4);
        DO = 32'd4;
        BtoR_REQ = 1'b1;
        step(10);
        chk("bp_no_ack", {31'd0, RtoB_ACK}, 32'd0);
        chk("bp_still_full", {29'd0, count}, 32'd4);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("bp_popped", {29'd0, count}, 32'd3);
        chk("bp_ack_p0", {31'd0, RtoB_ACK}, 32'd0);
        step(1);
        chk("bp_ack_p1", {31'd0, RtoB_ACK}, 32'd0);
        step(1);
        chk("bp_ack_p2", {31'd0, RtoB_ACK}, 32'd1);
        chk("bp_refull", {29'd0, count}, 32'd4);
        chk("bp_head", out_data, 32'd1);
        BtoR_REQ = 1'b0;
        wait_ack(1'b0, "bp_ack_fall");
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk("bp_drain_data", out_data, i);
            step(1);
        end
        chk("bp_empty", {29'd0, count}, 32'd0);

        // Sequence gap
        do_reset();
        out_ready = 1'b1;
        hs(32'd0);
        hs(32'd1);
        chk("gap_before", {31'd0, seq_err}, 32'd0);
        hs(32'd3);
        chk("gap_after3", {31'd0, seq_err}, {31'd0, SeqOn});
        hs(32'd4);
        chk("gap_sticky", {31'd0, seq_err}, {31'd0, SeqOn});

        // Reset mid-handshake
        do_reset();
        out_ready = 1'b0;
        DO = 32'h77;
        BtoR_REQ = 1'b1;
        wait_ack(1'b1, "rst_mid_ack");
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ack_low", {31'd0, RtoB_ACK}, 32'd0);
        chk("rst_mid_count", {29'd0, count}, 32'd0);
        step(2);
        rst_n = 1'b1;
        wait_ack(1'b1, "rst_recap_ack");
        chk("rst_recap_count", {29'd0, count}, 32'd1);
        chk("rst_recap_data", out_data, 32'h77);
        BtoR_REQ = 1'b0;
        wait_ack(1'b0, "rst_recap_fall");

        // One-cycle glitch on REQ
        do_reset();
        BtoR_REQ = 1'b1;
        step(1);
        BtoR_REQ = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("glitch_no_ack", {31'd0, RtoB_ACK}, 32'd0);
        end
        chk("glitch_count", {29'd0, count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
